// File: rtl/register_file_dual_port_if.sv
// Request/response bundle for register_file_dual_port.
//   master: drives write/read requests, receives read results, error flags,
//           exported registers and update strobes.
//   slave : the register file itself.
interface register_file_dual_port_if #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int EXPORTED_REGISTERS = 4
);
  logic                                     write_enable;
  logic [ADDRESS_WIDTH-1:0]                 write_address;
  logic [DATA_WIDTH-1:0]                    write_data;
  logic [DATA_WIDTH-1:0]                    write_mask;
  logic                                     read_enable;
  logic [ADDRESS_WIDTH-1:0]                 read_address;
  logic [DATA_WIDTH-1:0]                    read_data;
  logic                                     read_data_valid;
  logic                                     read_error;
  logic                                     write_error;
  logic [EXPORTED_REGISTERS*DATA_WIDTH-1:0] registers_out;
  logic [EXPORTED_REGISTERS-1:0]            update_strobe;

  modport master (
    output write_enable, write_address, write_data, write_mask,
           read_enable, read_address,
    input  read_data, read_data_valid, read_error, write_error,
           registers_out, update_strobe
  );

  modport slave (
    input  write_enable, write_address, write_data, write_mask,
           read_enable, read_address,
    output read_data, read_data_valid, read_error, write_error,
           registers_out, update_strobe
  );
endinterface

// File: rtl/register_file_dual_port.sv
// Dual-port register file: one masked write and one read per cycle, with
// write-first bypass on same-address collisions, range checking on both
// ports, and the low EXPORTED_REGISTERS registers exported as a flat bus with
// per-register one-cycle update strobes.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low
//   bus   - register_file_dual_port_if.slave (requests in, results out)
module register_file_dual_port #(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int EXPORTED_REGISTERS  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  register_file_dual_port_if.slave bus
);
  localparam int ADDRESS_WIDTH = $clog2(REGISTER_FILE_DEPTH);
  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(REGISTER_FILE_DEPTH);

  logic [DATA_WIDTH-1:0] storage [REGISTER_FILE_DEPTH];

  logic                    write_in_range;
  logic                    read_in_range;
  logic                    write_accept;
  logic                    collision;
  logic [DATA_WIDTH-1:0]   write_old;
  logic [DATA_WIDTH-1:0]   write_merged;
  logic [EXPORTED_REGISTERS-1:0] strobe_next;

  logic [DATA_WIDTH-1:0]         read_data_q;
  logic                          read_data_valid_q;
  logic                          read_error_q;
  logic                          write_error_q;
  logic [EXPORTED_REGISTERS-1:0] update_strobe_q;
  logic [EXPORTED_REGISTERS*DATA_WIDTH-1:0] exported;

  always_comb begin
    write_in_range = {1'b0, bus.write_address} < DEPTH_LIMIT;
    read_in_range  = {1'b0, bus.read_address} < DEPTH_LIMIT;
    write_accept   = bus.write_enable && write_in_range;
    write_old      = write_in_range ? storage[bus.write_address] : '0;
    write_merged   = (write_old & ~bus.write_mask) | (bus.write_data & bus.write_mask);
    // Write-first: a read of the register being written sees the merged value.
    collision      = write_accept && bus.read_enable &&
                     (bus.write_address == bus.read_address);
    strobe_next    = '0;
    for (int unsigned k = 0; k < EXPORTED_REGISTERS; k++) begin
      strobe_next[k] = write_accept && (bus.write_address == ADDRESS_WIDTH'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REGISTER_FILE_DEPTH; i++) begin
        storage[i] <= '0;
      end
      read_data_q       <= '0;
      read_data_valid_q <= 1'b0;
      read_error_q      <= 1'b0;
      write_error_q     <= 1'b0;
      update_strobe_q   <= '0;
    end else begin
      if (write_accept) begin
        storage[bus.write_address] <= write_merged;
      end
      write_error_q     <= bus.write_enable && !write_in_range;
      update_strobe_q   <= strobe_next;
      read_data_valid_q <= bus.read_enable;
      read_error_q      <= bus.read_enable && !read_in_range;
      if (bus.read_enable) begin
        if (!read_in_range) begin
          read_data_q <= '0;
        end else if (collision) begin
          read_data_q <= write_merged;
        end else begin
          read_data_q <= storage[bus.read_address];
        end
      end
    end
  end

  always_comb begin
    exported = '0;
    for (int unsigned k = 0; k < EXPORTED_REGISTERS; k++) begin
      exported[k*DATA_WIDTH +: DATA_WIDTH] = storage[k];
    end
  end

  assign bus.read_data       = read_data_q;
  assign bus.read_data_valid = read_data_valid_q;
  assign bus.read_error      = read_error_q;
  assign bus.write_error     = write_error_q;
  assign bus.update_strobe   = update_strobe_q;
  assign bus.registers_out   = exported;
endmodule

// File: tb/tb_register_file_dual_port.sv
// Self-checking bench: two instances (DEPTH=16 and DEPTH=12) driven with the
// same directed stimulus; a reference model predicts each cycle's outputs into
// a scoreboard queue that is popped and compared after the clock edge.
module tb_register_file_dual_port;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  register_file_dual_port_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .EXPORTED_REGISTERS(4)) bus_a ();
  register_file_dual_port_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .EXPORTED_REGISTERS(4)) bus_b ();

  register_file_dual_port #(.DATA_WIDTH(8), .REGISTER_FILE_DEPTH(16), .EXPORTED_REGISTERS(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  register_file_dual_port #(.DATA_WIDTH(8), .REGISTER_FILE_DEPTH(12), .EXPORTED_REGISTERS(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  typedef struct {
    logic        valid;
    logic        err;
    logic [7:0]  data;
    logic        werr;
    logic [3:0]  strobe;
    logic [31:0] regs;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [2][16];
  logic [7:0] last_rd [2];
  int         depth [2] = '{16, 12};
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic compare_dut(input string name, input exp_t got);
    exp_t want;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", name);
    end else begin
      want = sb.pop_front();
      check({name, ".valid"},  32'(got.valid),  32'(want.valid));
      check({name, ".rerr"},   32'(got.err),    32'(want.err));
      check({name, ".rdata"},  32'(got.data),   32'(want.data));
      check({name, ".werr"},   32'(got.werr),   32'(want.werr));
      check({name, ".strobe"}, 32'(got.strobe), 32'(want.strobe));
      check({name, ".regs"},   got.regs,        want.regs);
    end
  endtask

  task automatic cycle(input logic rst_n, input logic we, input logic [3:0] wa,
                       input logic [7:0] wd, input logic [7:0] wm,
                       input logic re, input logic [3:0] ra);
    exp_t       e;
    exp_t       got;
    logic [7:0] merged;
    logic       whit;
    reset = rst_n;
    bus_a.write_enable = we; bus_a.write_address = wa; bus_a.write_data = wd;
    bus_a.write_mask = wm;   bus_a.read_enable = re;   bus_a.read_address = ra;
    bus_b.write_enable = we; bus_b.write_address = wa; bus_b.write_data = wd;
    bus_b.write_mask = wm;   bus_b.read_enable = re;   bus_b.read_address = ra;
    for (int d = 0; d < 2; d++) begin
      whit   = we && (int'(wa) < depth[d]);
      merged = (mdl[d][wa] & ~wm) | (wd & wm);
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) mdl[d][i] = 8'h00;
        last_rd[d] = 8'h00;
        e = '{valid: 1'b0, err: 1'b0, data: 8'h00, werr: 1'b0, strobe: 4'h0, regs: 32'h0};
      end else begin
        e.valid = re;
        e.err   = re && (int'(ra) >= depth[d]);
        if (re) begin
          if (e.err) last_rd[d] = 8'h00;
          else if (whit && wa == ra) last_rd[d] = merged;
          else last_rd[d] = mdl[d][ra];
        end
        e.data   = last_rd[d];
        e.werr   = we && !whit;
        e.strobe = (whit && wa < 4'd4) ? 4'(1 << wa) : 4'h0;
        if (whit) mdl[d][wa] = merged;
        e.regs = {mdl[d][3], mdl[d][2], mdl[d][1], mdl[d][0]};
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    got = '{valid: bus_a.read_data_valid, err: bus_a.read_error, data: bus_a.read_data,
            werr: bus_a.write_error, strobe: bus_a.update_strobe, regs: bus_a.registers_out};
    compare_dut("d16", got);
    got = '{valid: bus_b.read_data_valid, err: bus_b.read_error, data: bus_b.read_data,
            werr: bus_b.write_error, strobe: bus_b.update_strobe, regs: bus_b.registers_out};
    compare_dut("d12", got);
  endtask

  initial begin
    // reset, including a request presented during reset that must be dropped
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0);
    cycle(1'b0, 1'b1, 4'd2, 8'hFF, 8'hFF, 1'b1, 4'd2);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2);
    // write addr 14 then read it back; read port idle afterwards holds data
    cycle(1'b1, 1'b1, 4'd14, 8'hF4, 8'hFF, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd14);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0);
    // masked write into exported register 2
    cycle(1'b1, 1'b1, 4'd2, 8'hAA, 8'hFF, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 4'd2, 8'h55, 8'h0F, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2);
    // collisions: full mask, then partial mask
    cycle(1'b1, 1'b1, 4'd1, 8'h00, 8'hFF, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 4'd1, 8'h3C, 8'hFF, 1'b1, 4'd1);
    cycle(1'b1, 1'b1, 4'd1, 8'hC3, 8'hF0, 1'b1, 4'd1);
    // range boundaries (out of range only on the 12-deep instance)
    cycle(1'b1, 1'b1, 4'd13, 8'h77, 8'hFF, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd15);
    cycle(1'b1, 1'b1, 4'd11, 8'h6B, 8'hFF, 1'b1, 4'd11);
    cycle(1'b1, 1'b1, 4'd12, 8'h5A, 8'hFF, 1'b1, 4'd12);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd11);
    // zero-mask write is still accepted and strobes
    cycle(1'b1, 1'b1, 4'd3, 8'hFF, 8'h00, 1'b1, 4'd3);
    // back-to-back writes to exported registers with concurrent reads
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 4'(i), 8'(i * 17 + 1), 8'hFF, 1'b1, 4'(i ^ 1));
    // reset mid-stream, then every address must read zero
    cycle(1'b0, 1'b1, 4'd5, 8'h99, 8'hFF, 1'b1, 4'd5);
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'(i));
    // sustained throughput: write addr i, read addr i-1
    for (int i = 0; i <= 16; i++)
      cycle(1'b1, (i < 16), 4'(i), 8'(i * 3), 8'hFF, (i > 0), 4'(i - 1));
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
